// File: rtl/mask_unit_read_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mask_unit_read_pkg
//  Description : Shared constants, scheduler state encoding and the per-slot
//                read request record for the mask-unit read scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package mask_unit_read_pkg;

    localparam int NUM_SLOT = 4;   // requesters = crossbar inputs = lanes
    localparam int IDX_W    = 2;   // log2(NUM_SLOT)
    localparam int VS_W     = 5;   // vector register index width
    localparam int OFF_W    = 4;   // offset width
    localparam int DATA_W   = 32;  // read data width per slot

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // One crossbar request as presented by a single slot.
    typedef struct packed {
        logic [VS_W-1:0]  vs;
        logic [OFF_W-1:0] offset;
        logic [IDX_W-1:0] read_lane;
        logic [IDX_W-1:0] data_offset;
    } slot_req_t;

endpackage
`default_nettype wire

// File: rtl/mask_unit_resp_collect.sv
`default_nettype none
// ============================================================================
//  Module      : mask_unit_resp_collect
//  Description : Routes lane responses to slots by write index, captures data
//                for outstanding slots into the result buffer, and flags
//                stray or duplicated responses.
//  Ports       : i_clock/i_reset     clock, async active-high reset
//                i_clear             new group accepted, zero the buffer
//                i_active            scheduler busy (responses ignored in IDLE)
//                i_drain             flushed group draining: discard, no error
//                i_outstanding       slots awaiting data
//                i_resp_*            per-lane response valid/index/data
//                o_clr               slots whose data arrived this cycle
//                o_err               protocol error seen this cycle
//                o_buffer            captured data, slot i at [i*DATA_W+:DATA_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module mask_unit_resp_collect
    import mask_unit_read_pkg::*;
(
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_clear,
    input  logic                       i_active,
    input  logic                       i_drain,
    input  logic [NUM_SLOT-1:0]        i_outstanding,
    input  logic [NUM_SLOT-1:0]        i_resp_valid,
    input  logic [NUM_SLOT*IDX_W-1:0]  i_resp_write_index,
    input  logic [NUM_SLOT*DATA_W-1:0] i_resp_data,
    output logic [NUM_SLOT-1:0]        o_clr,
    output logic                       o_err,
    output logic [NUM_SLOT*DATA_W-1:0] o_buffer
);

    logic [NUM_SLOT-1:0]        w_clr;
    logic [NUM_SLOT-1:0]        w_claimed;
    logic [IDX_W-1:0]           w_slot;
    logic                       w_err;
    logic [DATA_W-1:0]          w_sel_data [NUM_SLOT];
    logic [NUM_SLOT*DATA_W-1:0] r_buffer;

    // Lanes are scanned lowest first, so on a collision the lowest lane has
    // already claimed the slot and every later lane is the one dropped.
    // A slot whose request fires this cycle is not yet outstanding, so a
    // same-cycle response to it falls into the stray-response path.
    always_comb begin
        w_clr     = '0;
        w_claimed = '0;
        w_err     = 1'b0;
        w_slot    = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            w_sel_data[s] = '0;
        end
        if (i_active) begin
            for (int l = 0; l < NUM_SLOT; l++) begin
                if (i_resp_valid[l]) begin
                    w_slot = i_resp_write_index[l*IDX_W +: IDX_W];
                    if (w_claimed[w_slot]) begin
                        w_err = 1'b1;
                    end else begin
                        w_claimed[w_slot] = 1'b1;
                        if (i_outstanding[w_slot]) begin
                            w_clr[w_slot]      = 1'b1;
                            w_sel_data[w_slot] = i_resp_data[l*DATA_W +: DATA_W];
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_buffer <= '0;
        end else if (i_clear) begin
            r_buffer <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOT; s++) begin
                if (w_clr[s] && !i_drain) begin
                    r_buffer[s*DATA_W +: DATA_W] <= w_sel_data[s];
                end
            end
        end
    end

    assign o_clr    = w_clr;
    assign o_err    = w_err & ~i_drain;
    assign o_buffer = r_buffer;

endmodule
`default_nettype wire

// File: rtl/mask_unit_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mask_unit_read_scheduler
//  Description : Sequences one multi-slot register read through the 4x4
//                mask-unit read crossbar: latches a group command, retries
//                per-slot requests until accepted, collects responses by
//                write index and hands the complete group to the mask unit.
//                Flush drains in-flight responses before the next group.
//  Ports       : i_clock/i_reset        clock, async active-high reset
//                i_flush                abort current group
//                i_cmd_*/o_cmd_ready    group command handshake and fields
//                o_req_*/i_req_ready    per-slot crossbar requests
//                i_resp_*               per-lane read responses
//                o_result_*/i_result_ready  completed group handshake
//                o_error                sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module mask_unit_read_scheduler
    import mask_unit_read_pkg::*;
(
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [VS_W-1:0]            i_cmd_vs,
    input  logic [OFF_W-1:0]           i_cmd_offset,
    input  logic [NUM_SLOT-1:0]        i_cmd_mask,
    input  logic [NUM_SLOT*IDX_W-1:0]  i_cmd_read_lane,
    input  logic [NUM_SLOT*IDX_W-1:0]  i_cmd_data_offset,
    output logic [NUM_SLOT-1:0]        o_req_valid,
    input  logic [NUM_SLOT-1:0]        i_req_ready,
    output logic [VS_W-1:0]            o_req_vs,
    output logic [OFF_W-1:0]           o_req_offset,
    output logic [NUM_SLOT*IDX_W-1:0]  o_req_read_lane,
    output logic [NUM_SLOT*IDX_W-1:0]  o_req_data_offset,
    input  logic [NUM_SLOT-1:0]        i_resp_valid,
    input  logic [NUM_SLOT*IDX_W-1:0]  i_resp_write_index,
    input  logic [NUM_SLOT*DATA_W-1:0] i_resp_data,
    output logic                       o_result_valid,
    input  logic                       i_result_ready,
    output logic [NUM_SLOT-1:0]        o_result_mask,
    output logic [NUM_SLOT*DATA_W-1:0] o_result_data,
    output logic                       o_error
);

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_SLOT-1:0] r_pending;      // not yet accepted by the crossbar
    logic [NUM_SLOT-1:0] r_outstanding;  // accepted, data not yet returned
    logic [NUM_SLOT-1:0] r_received;     // data captured
    logic [NUM_SLOT-1:0] r_mask;
    logic                r_error;
    slot_req_t           r_req [NUM_SLOT];

    logic [NUM_SLOT-1:0] w_pending_next;
    logic [NUM_SLOT-1:0] w_outstanding_next;
    logic [NUM_SLOT-1:0] w_received_next;
    logic [NUM_SLOT-1:0] w_fire;
    logic [NUM_SLOT-1:0] w_clr;
    logic [NUM_SLOT-1:0] w_out_after;
    logic                w_cmd_fire;
    logic                w_resp_err;

    assign o_cmd_ready    = (r_state == IDLE);
    assign w_cmd_fire     = i_cmd_valid & o_cmd_ready;
    assign o_req_valid    = (r_state == ISSUE) ? r_pending : '0;
    assign w_fire         = o_req_valid & i_req_ready;
    // Outstanding set after this cycle's responses and grants; fire and clear
    // never overlap because a slot is pending or outstanding, never both.
    assign w_out_after    = (r_outstanding & ~w_clr) | w_fire;
    assign o_result_valid = (r_state == DONE);
    assign o_result_mask  = r_mask;
    assign o_error        = r_error;
    assign o_req_vs       = r_req[0].vs;
    assign o_req_offset   = r_req[0].offset;

    generate
        for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
            assign o_req_read_lane[i*IDX_W +: IDX_W]   = r_req[i].read_lane;
            assign o_req_data_offset[i*IDX_W +: IDX_W] = r_req[i].data_offset;
        end
    endgenerate

    mask_unit_resp_collect u_collect (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_clear            (w_cmd_fire),
        .i_active           (r_state != IDLE),
        .i_drain            (r_state == DRAIN),
        .i_outstanding      (r_outstanding),
        .i_resp_valid       (i_resp_valid),
        .i_resp_write_index (i_resp_write_index),
        .i_resp_data        (i_resp_data),
        .o_clr              (w_clr),
        .o_err              (w_resp_err),
        .o_buffer           (o_result_data)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pending_next     = r_pending;
        w_outstanding_next = w_out_after;
        w_received_next    = r_received | w_clr;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_pending_next  = i_cmd_mask;
                    w_received_next = '0;
                    w_state_next    = (i_cmd_mask == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                w_pending_next = r_pending & ~w_fire;
                if (w_pending_next == '0) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if ((((r_received | w_clr) & r_mask) == r_mask) && (w_out_after == '0)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (i_result_ready) begin
                    w_state_next = IDLE;
                end
            end
            DRAIN: begin
                if (w_out_after == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // A request granted in the flush cycle will still return data, so the
        // drain decision uses the post-grant outstanding set.
        if (i_flush && (r_state != IDLE)) begin
            w_pending_next = '0;
            w_state_next   = (w_out_after != '0) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_received    <= '0;
            r_mask        <= '0;
            r_error       <= 1'b0;
            for (int i = 0; i < NUM_SLOT; i++) begin
                r_req[i] <= '0;
            end
        end else begin
            r_pending     <= w_pending_next;
            r_outstanding <= w_outstanding_next;
            r_received    <= w_received_next;
            r_error       <= r_error | w_resp_err;
            if (w_cmd_fire) begin
                r_mask <= i_cmd_mask;
                for (int i = 0; i < NUM_SLOT; i++) begin
                    r_req[i] <= '{vs:          i_cmd_vs,
                                  offset:      i_cmd_offset,
                                  read_lane:   i_cmd_read_lane[i*IDX_W +: IDX_W],
                                  data_offset: i_cmd_data_offset[i*IDX_W +: IDX_W]};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mask_unit_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mask_unit_read_scheduler
//  Description : Self-checking bench for mask_unit_read_scheduler. A slot-
//                status model (none/pending/outstanding/got) predicts outputs
//                every cycle; directed tests pin key cycles with literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_unit_read_scheduler;

    localparam int NONE = 0, PEND = 1, OUTS = 2, GOT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         flush, cmd_valid, result_ready, auto_en;
    logic [4:0]   cmd_vs;
    logic [3:0]   cmd_offset, cmd_mask;
    logic [7:0]   cmd_lane, cmd_doff;
    int           ready_mode;
    logic [3:0]   man_valid, auto_valid;
    logic [7:0]   man_idx, auto_idx;
    logic [127:0] man_data, auto_data;

    logic         o_cmd_ready, o_result_valid, o_error;
    logic [3:0]   o_req_valid, o_result_mask, req_ready, resp_valid;
    logic [4:0]   o_req_vs;
    logic [3:0]   o_req_offset;
    logic [7:0]   o_req_read_lane, o_req_data_offset, resp_idx;
    logic [127:0] o_result_data, resp_data;

    assign req_ready  = (ready_mode == 1) ? 4'hF :
                        (ready_mode == 2) ? (o_req_valid & (~o_req_valid + 4'd1)) : 4'h0;
    assign resp_valid = auto_en ? auto_valid : man_valid;
    assign resp_idx   = auto_en ? auto_idx   : man_idx;
    assign resp_data  = auto_en ? auto_data  : man_data;

    mask_unit_read_scheduler dut (
        .i_clock(clk), .i_reset(rst), .i_flush(flush),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_vs(cmd_vs), .i_cmd_offset(cmd_offset), .i_cmd_mask(cmd_mask),
        .i_cmd_read_lane(cmd_lane), .i_cmd_data_offset(cmd_doff),
        .o_req_valid(o_req_valid), .i_req_ready(req_ready),
        .o_req_vs(o_req_vs), .o_req_offset(o_req_offset),
        .o_req_read_lane(o_req_read_lane), .o_req_data_offset(o_req_data_offset),
        .i_resp_valid(resp_valid), .i_resp_write_index(resp_idx), .i_resp_data(resp_data),
        .o_result_valid(o_result_valid), .i_result_ready(result_ready),
        .o_result_mask(o_result_mask), .o_result_data(o_result_data),
        .o_error(o_error)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] rdata(input logic [4:0] vs, input int lane, input int slot);
        return 32'hC0DE_0000 | (32'(vs) << 8) | (32'(lane) << 4) | 32'(slot);
    endfunction

    // ---------------- crossbar responder: one-cycle response latency -------
    logic [3:0] fire_q;
    logic [7:0] lane_q;
    logic [4:0] vs_q;
    always @(negedge clk) begin
        fire_q = o_req_valid & req_ready;
        lane_q = o_req_read_lane;
        vs_q   = o_req_vs;
    end
    always @(posedge clk) begin
        #1;
        auto_valid = '0;
        auto_idx   = '0;
        auto_data  = '0;
        for (int i = 0; i < 4; i++) begin
            if (fire_q[i]) begin
                int l;
                l = int'(lane_q[2*i +: 2]);
                auto_valid[l]        = 1'b1;
                auto_idx[2*l +: 2]   = 2'(i);
                auto_data[32*l +: 32] = rdata(vs_q, l, i);
            end
        end
    end

    // ---------------- behavioural model ------------------------------------
    int          mphase;  // 0 idle, 1 collecting, 2 result ready, 3 draining
    int          st [4];
    logic [31:0] mdata [4];
    logic [3:0]  mmask;
    logic [4:0]  mvs;
    logic [3:0]  moff;
    logic [7:0]  mlane, mdoff;
    logic        merr;

    logic         s_cmd_valid, s_flush, s_result_ready;
    logic [3:0]   s_mask, s_req_ready, s_resp_valid;
    logic [4:0]   s_vs;
    logic [3:0]   s_off;
    logic [7:0]   s_lane, s_doff, s_resp_idx;
    logic [127:0] s_resp_data;

    always @(negedge clk) begin
        s_cmd_valid = cmd_valid;   s_flush = flush;     s_result_ready = result_ready;
        s_mask = cmd_mask;         s_vs = cmd_vs;       s_off = cmd_offset;
        s_lane = cmd_lane;         s_doff = cmd_doff;   s_req_ready = req_ready;
        s_resp_valid = resp_valid; s_resp_idx = resp_idx; s_resp_data = resp_data;
    end

    task automatic model_reset();
        mphase = 0; merr = 1'b0; mmask = '0; mvs = '0; moff = '0; mlane = '0; mdoff = '0;
        for (int i = 0; i < 4; i++) begin st[i] = NONE; mdata[i] = '0; end
    endtask

    task automatic model_step();
        logic [3:0] seen;
        bit anyout, allgot;
        if (mphase == 0) begin
            if (s_cmd_valid) begin
                mmask = s_mask; mvs = s_vs; moff = s_off; mlane = s_lane; mdoff = s_doff;
                for (int i = 0; i < 4; i++) begin
                    mdata[i] = '0;
                    st[i] = s_mask[i] ? PEND : NONE;
                end
                mphase = (s_mask == 4'h0) ? 2 : 1;
            end
            return;
        end
        seen = '0;
        for (int l = 0; l < 4; l++) begin
            if (s_resp_valid[l]) begin
                int s;
                s = int'(s_resp_idx[2*l +: 2]);
                if (seen[s]) begin
                    if (mphase != 3) merr = 1'b1;
                end else begin
                    seen[s] = 1'b1;
                    if (st[s] == OUTS) begin
                        if (mphase == 3) st[s] = NONE;
                        else begin st[s] = GOT; mdata[s] = s_resp_data[32*l +: 32]; end
                    end else if (mphase != 3) merr = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) if (st[i] == PEND && s_req_ready[i]) st[i] = OUTS;
        anyout = 0; allgot = 1;
        for (int i = 0; i < 4; i++) begin
            if (st[i] == OUTS) anyout = 1;
            if (mmask[i] && st[i] != GOT) allgot = 0;
        end
        if (s_flush) begin
            for (int i = 0; i < 4; i++) if (st[i] == PEND) st[i] = NONE;
            mphase = anyout ? 3 : 0;
        end else if (mphase == 1 && allgot) mphase = 2;
        else if (mphase == 2 && s_result_ready) mphase = 0;
        else if (mphase == 3 && !anyout) mphase = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        logic [3:0]   erv;
        logic [127:0] edata;
        for (int i = 0; i < 4; i++) begin
            erv[i] = (st[i] == PEND);
            edata[32*i +: 32] = mdata[i];
        end
        chk("m_cmd_ready", {127'd0, o_cmd_ready}, {127'd0, mphase == 0});
        chk("m_req_valid", {124'd0, o_req_valid}, {124'd0, erv});
        chk("m_result_valid", {127'd0, o_result_valid}, {127'd0, mphase == 2});
        chk("m_error", {127'd0, o_error}, {127'd0, merr});
        if (mphase == 2) begin
            chk("m_result_mask", {124'd0, o_result_mask}, {124'd0, mmask});
            chk("m_result_data", o_result_data, edata);
        end
        if (mphase != 0) begin
            chk("m_req_fields", {103'd0, o_req_vs, o_req_offset, o_req_read_lane, o_req_data_offset},
                                {103'd0, mvs, moff, mlane, mdoff});
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [3:0] m, input logic [4:0] vs, input logic [3:0] off,
                            input logic [7:0] lane, input logic [7:0] doff);
        cmd_mask = m; cmd_vs = vs; cmd_offset = off; cmd_lane = lane; cmd_doff = doff;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic take_result(input string name, input logic [127:0] exp_data, input logic [3:0] exp_mask);
        for (int k = 0; k < 20 && !o_result_valid; k++) step();
        chk({name, "_valid"}, {127'd0, o_result_valid}, 128'd1);
        if (o_result_valid) begin
            chk({name, "_data"}, o_result_data, exp_data);
            chk({name, "_mask"}, {124'd0, o_result_mask}, {124'd0, exp_mask});
            result_ready = 1'b1;
            step();
            result_ready = 1'b0;
        end
    endtask

    task automatic man_clear();
        man_valid = '0; man_idx = '0; man_data = '0;
    endtask

    initial begin
        logic [3:0] t2_exp [4];
        t2_exp[0] = 4'hF; t2_exp[1] = 4'hE; t2_exp[2] = 4'hC; t2_exp[3] = 4'h8;
        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; result_ready = 1'b0; auto_en = 1'b1;
        cmd_vs = '0; cmd_offset = '0; cmd_mask = '0; cmd_lane = '0; cmd_doff = '0;
        ready_mode = 1;
        man_clear();
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_cmd_ready", {127'd0, o_cmd_ready}, 128'd1);
        chk("reset_outputs", {121'd0, o_req_valid, o_result_valid, o_error}, 128'd0);

        // 1: all slots on distinct lanes, granted at once
        send_cmd(4'hF, 5'd3, 4'd5, 8'hE4, 8'h1B);
        chk("t1_req_T1", {124'd0, o_req_valid}, {124'd0, 4'hF});
        step();
        chk("t1_req_T2", {123'd0, o_req_valid, o_result_valid}, 128'd0);
        step();
        chk("t1_valid_T3", {127'd0, o_result_valid}, 128'd1);
        chk("t1_data", o_result_data, 128'hC0DE0333_C0DE0322_C0DE0311_C0DE0300);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("t1_cmd_ready_after", {127'd0, o_cmd_ready}, 128'd1);

        // 2: all on lane 0, one grant per cycle
        ready_mode = 2;
        send_cmd(4'hF, 5'd7, 4'd2, 8'h00, 8'hE4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_req_seq", {124'd0, o_req_valid}, {124'd0, t2_exp[k]});
            step();
        end
        chk("t2_req_done", {124'd0, o_req_valid}, 128'd0);
        take_result("t2", 128'hC0DE0703_C0DE0702_C0DE0701_C0DE0700, 4'hF);

        // 3: sparse mask, responses out of order
        ready_mode = 1; auto_en = 1'b0;
        send_cmd(4'h5, 5'd9, 4'd1, 8'h31, 8'h00);
        chk("t3_req", {124'd0, o_req_valid}, {124'd0, 4'h5});
        step();
        man_valid = 4'b1000; man_idx = 8'h80; man_data[127:96] = 32'hAAAA2222;
        step();
        man_clear();
        man_valid = 4'b0010; man_idx = 8'h00; man_data[63:32] = 32'h11110000;
        step();
        man_clear();
        take_result("t3", 128'h00000000_AAAA2222_00000000_11110000, 4'h5);
        chk("t3_error", {127'd0, o_error}, 128'd0);

        // 4: empty mask completes immediately
        send_cmd(4'h0, 5'd1, 4'd0, 8'h00, 8'h00);
        chk("t4_valid_T1", {123'd0, o_req_valid, o_result_valid}, 128'd1);
        take_result("t4", 128'd0, 4'h0);

        // 5: flush with two outstanding, late responses drained
        send_cmd(4'h3, 5'd4, 4'd6, 8'h0E, 8'h00);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_drain", {123'd0, o_req_valid, o_cmd_ready}, 128'd0);
        man_valid = 4'b1100; man_idx = 8'h40; man_data = {32'hDEAD0001, 32'hDEAD0000, 64'd0};
        step();
        man_clear();
        chk("t5_idle_noerr", {126'd0, o_cmd_ready, o_error}, 128'd2);
        auto_en = 1'b1;
        send_cmd(4'hF, 5'd2, 4'd3, 8'hE4, 8'h00);
        take_result("t5_next", 128'hC0DE0233_C0DE0222_C0DE0211_C0DE0200, 4'hF);

        // 6a: stray response while the result waits
        auto_en = 1'b0;
        send_cmd(4'h1, 5'd4, 4'd0, 8'h00, 8'h00);
        step();
        man_valid = 4'b0001; man_idx = 8'h00; man_data[31:0] = 32'h12345678;
        step();
        man_clear();
        chk("t6_err_before", {127'd0, o_error}, 128'd0);
        man_valid = 4'b0010; man_idx = 8'h0C; man_data[63:32] = 32'h0BAD0BAD;
        step();
        man_clear();
        chk("t6_err_stray", {127'd0, o_error}, 128'd1);
        take_result("t6a", {96'd0, 32'h12345678}, 4'h1);
        chk("t6_err_sticky", {127'd0, o_error}, 128'd1);

        // 6b: async reset in the middle of ISSUE
        ready_mode = 0;
        send_cmd(4'hF, 5'd5, 4'd1, 8'hE4, 8'h00);
        step();
        chk("t6_issue", {124'd0, o_req_valid}, {124'd0, 4'hF});
        #2 rst = 1'b1;
        #1;
        chk("t6_async_reset", {125'd0, o_cmd_ready, o_result_valid, o_error}, 128'd4);
        chk("t6_async_req", {124'd0, o_req_valid}, 128'd0);
        step();
        rst = 1'b0;
        step();

        // 6c: two lanes to the same slot, lowest lane wins
        ready_mode = 1;
        send_cmd(4'h1, 5'd6, 4'd0, 8'h00, 8'h00);
        step();
        man_valid = 4'b0101; man_idx = 8'h00; man_data = {32'd0, 32'h0000BBBB, 32'd0, 32'h0000AAAA};
        step();
        man_clear();
        chk("t6_err_dup", {127'd0, o_error}, 128'd1);
        take_result("t6c", {96'd0, 32'h0000AAAA}, 4'h1);

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
